regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (regWrite/writeReg/writeData)
//  between NUM_REQ writeback requesters (e.g. ALU, load unit, CSR unit).
//  Round-robin arbitration over valid/ready handshakes feeds a registered
//  write stage that drives the register file directly.
//  Suppresses writes to x0 and counts arbitration conflicts for debug.
// PARAMETERS
//  NUM_REQ  3   number of writeback requesters (2..8)
//  DATA_W   32  write data width
//  ADDR_W   5   register index width
//  CNT_W    16  conflict counter width
// PORTS
//  clk         in   1               rising-edge clock
//  rst_n       in   1               asynchronous active-low reset
//  req_valid   in   NUM_REQ         requester i has a write pending
//  req_ready   out  NUM_REQ         grant; transfer when valid&ready
//  req_reg     in   NUM_REQ*ADDR_W  dest index, requester i at [i*ADDR_W+:ADDR_W]
//  req_data    in   NUM_REQ*DATA_W  write data, requester i at [i*DATA_W+:DATA_W]
//  regWrite    out  1               register-file write enable
//  writeReg    out  ADDR_W          register-file write index
//  writeData   out  DATA_W          register-file write data
//  grant_id    out  $clog2(NUM_REQ) requester that produced current write
//  conflict_cnt out CNT_W           saturating count of contention cycles
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-low (rst_n).
//  - Reset: req_ready=0, regWrite=0, writeReg=0, writeData=0, grant_id=0,
//    conflict_cnt=0, RR pointer=0. In-flight write discarded.
//  - req_ready is combinational from req_valid and RR pointer; at most one
//    bit high per cycle; never high for a requester with req_valid=0.
//  - Winner: first valid requester scanning from pointer p upward, mod NUM_REQ.
//  - On transfer from requester i in cycle t: pointer <= (i+1) mod NUM_REQ;
//    writeReg/writeData/grant_id latched; regWrite=1 in cycle t+1 only.
//    Latency request->regfile write = 1 cycle; throughput 1 write/cycle.
//  - No transfer in cycle t: regWrite=0 in t+1; writeReg/writeData/grant_id hold.
//  - req_reg==0: granted and consumed normally (pointer advances) but
//    regWrite stays 0 in t+1 (x0 is hardwired zero).
//  - Same dest from two requesters same cycle: only winner writes; loser
//    stays pending and writes on a later grant (later write wins in regfile).
//  - Requester must hold valid/reg/data stable until ready; arbiter does not
//    check this.
//  - conflict_cnt increments by 1 each cycle with >=2 req_valid bits set;
//    saturates at 2^CNT_W-1, no wrap.
//  - Pointer only moves on transfer; idle cycles leave it unchanged.
// CONFIGURATION
//  REGFILE_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 highest,
//    pointer held at 0 (never updated); starvation of high indices allowed.
//  Not defined (default): round-robin as described above.
//  All other behaviour (latency, x0 rule, counter) identical in both builds.
// TESTING
//  1 Reset: rst_n=0 mid-transfer -> next edge not needed; all outputs 0
//    immediately, regWrite=0 with req_valid held high.
//  2 Single req: req_valid=3'b010, reg=7, data=32'hDEADBEEF -> req_ready=3'b010
//    cycle t; cycle t+1 regWrite=1, writeReg=7, writeData=DEADBEEF, grant_id=1.
//  3 All valid held 6 cycles from reset -> grant order 0,1,2,0,1,2 (RR);
//    with REGFILE_ARB_FIXED_PRIO_EN -> 0,0,0,0,0,0; conflict_cnt=6.
//  4 x0 write: req 0 reg=0, data=5 -> req_ready[0]=1, regWrite=0 in t+1,
//    pointer advances (next contended grant goes to req 1).
//  5 Back-to-back: req 2 valid 4 cycles, regs 1..4 -> regWrite=1 four
//    consecutive cycles, writeReg 1,2,3,4, no bubbles.
//  6 Saturation: CNT_W=4, two valid for 20 cycles -> conflict_cnt=15, holds.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Purpose: bundles the writeback requester handshakes and the register-file write port.
// Latency: none (wires only); the arbiter adds one cycle from grant to register-file write.
// Backpressure: req_ready is the per-requester grant; a requester holds valid/reg/data until granted.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester side: one lane per requester, packed lane i at [i*W +: W].
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    // Register-file write port and debug outputs.
    logic                      regWrite;
    logic [ADDR_W-1:0]         writeReg;
    logic [DATA_W-1:0]         writeData;
    logic [ID_W-1:0]           grant_id;
    logic [CNT_W-1:0]          conflict_cnt;

    // Requesters and register-file observer.
    modport master (
        output req_valid,
        output req_reg,
        output req_data,
        input  req_ready,
        input  regWrite,
        input  writeReg,
        input  writeData,
        input  grant_id,
        input  conflict_cnt
    );

    // The arbiter itself.
    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_data,
        output req_ready,
        output regWrite,
        output writeReg,
        output writeData,
        output grant_id,
        output conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin arbiter sharing one register-file write port among NUM_REQ writeback requesters.
// Latency: 1 cycle from valid&ready to regWrite; sustains one write per cycle.
// Backpressure: combinational one-hot req_ready; losers simply stay pending with inputs held.
// Build option: define REGFILE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  wb
);
    localparam int              ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int              LAST     = NUM_REQ - 1;
    localparam logic [ID_W-1:0] LAST_IDX = LAST[ID_W-1:0];
    localparam logic [ID_W:0]   NREQ_W   = NUM_REQ[ID_W:0];

    // Round-robin pointer: the requester scanned first in the current cycle.
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;

    // Registered write stage driving the register file directly.
    logic               wr_en_q;
    logic               wr_en_d;
    logic [ADDR_W-1:0]  wr_reg_q;
    logic [ADDR_W-1:0]  wr_reg_d;
    logic [DATA_W-1:0]  wr_data_q;
    logic [DATA_W-1:0]  wr_data_d;
    logic [ID_W-1:0]    wr_id_q;
    logic [ID_W-1:0]    wr_id_d;

    // Saturating contention counter.
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Arbitration results.
    logic [NUM_REQ-1:0] gnt_vec;
    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W:0]      scan_idx;
    logic               xfer;
    logic               multi_vld;

    // Selected requester payload.
    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_data;

    // Scan upward from the pointer, wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        gnt_vec   = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + k[ID_W:0];
            if (scan_idx >= NREQ_W) begin
                scan_idx = scan_idx - NREQ_W;
            end
            if (!gnt_found && wb.req_valid[scan_idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[ID_W-1:0];
                gnt_vec[scan_idx[ID_W-1:0]] = 1'b1;
            end
        end
    end

    // Grant is suppressed while reset is asserted so nothing is consumed during reset.
    assign wb.req_ready = gnt_vec & {NUM_REQ{rst_n}};
    assign xfer         = gnt_found & rst_n;

    // One-hot mux of the granted requester's destination index and data.
    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vec[i]) begin
                sel_reg  = sel_reg  | wb.req_reg[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | wb.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves past the winner on a transfer only; fixed-priority build pins it at 0.
    always_comb begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
`endif
    end

    // Latch the winning write; x0 is consumed and latched but never enables the write.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        wr_id_d   = wr_id_q;
        if (xfer) begin
            wr_en_d   = (sel_reg != '0);
            wr_reg_d  = sel_reg;
            wr_data_d = sel_data;
            wr_id_d   = gnt_idx;
        end
    end

    // Two or more simultaneous requests count as one contention cycle; counter sticks at max.
    assign multi_vld = |(wb.req_valid & (wb.req_valid - 1'b1));

    // Saturating increment of the contention counter.
    always_comb begin
        cnt_d = cnt_q;
        if (multi_vld && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            wr_id_q   <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            wr_id_q   <= wr_id_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wb.regWrite     = wr_en_q;
    assign wb.writeReg     = wr_reg_q;
    assign wb.writeData    = wr_data_q;
    assign wb.grant_id     = wr_id_q;
    assign wb.conflict_cnt = cnt_q;
endmodule
